vga_timing_gen: RTL and testbench

Parametrised video timing generator for the VGA/FPGA examples: produces horizontal/vertical sync, blanking, active-area flag, beam position, line/frame strobes and a frame counter for any VESA-style mode. Sits between the board pixel clock and the pixel-generation logic. Every output is registered and cycle-aligned with `hpos`/`vpos`. A clock-enable allows a fast system clock to be divided down to pixel rate.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/sync_axis_counter.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing description for the video timing generator: mode record,
// common presets and the per-axis total helper.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_display;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_display;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
    logic        hsync_pol;
    logic        vsync_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 =
    '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam vga_timing_t SVGA_800x600_60 =
    '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam vga_timing_t HD_1280x720_60 =
    '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};

  function automatic int unsigned total(input int unsigned display,
                                        input int unsigned front,
                                        input int unsigned sync,
                                        input int unsigned back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis: wrapping position counter plus sync/blank decode that is
// registered from the next position, so it lines up with pos.
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISPLAY = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48,
  parameter bit          POL     = 1'b0,
  parameter int unsigned W       = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  output logic         wrap,
  output logic [W-1:0] pos,
  output logic         sync,
  output logic         blank,
  output logic         blank_next
);

  localparam int unsigned TOTAL = total(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] DISP_END   = W'(DISPLAY);
  localparam logic [W-1:0] SYNC_FIRST = W'(DISPLAY + FRONT);
  localparam logic [W-1:0] SYNC_LAST  = W'(DISPLAY + FRONT + SYNC - 1);

  logic [W-1:0] pos_q, pos_d;
  logic         sync_q, sync_d;
  logic         blank_q, blank_d;

  always_comb begin
    pos_d = pos_q;
    if (advance) begin
      pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
    end
    sync_d  = ((pos_d >= SYNC_FIRST) && (pos_d <= SYNC_LAST)) ? POL : ~POL;
    blank_d = (pos_d >= DISP_END);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pos_q   <= LAST;
      sync_q  <= ~POL;
      blank_q <= 1'b1;
    end else begin
      pos_q   <= pos_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
    end
  end

  assign wrap       = advance && (pos_q == LAST);
  assign pos        = pos_q;
  assign sync       = sync_q;
  assign blank      = blank_q;
  assign blank_next = blank_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: two chained axis counters plus the active-area
// flag, line/frame strobes and frame counter, all registered together.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CW        = 12,
  parameter int unsigned FW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          hblank,
  output logic          vblank,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int unsigned H_TOTAL = total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > (64'd1 << CW) || V_TOTAL > (64'd1 << CW)) begin : g_bad_total
    $error("vga_timing_gen: line or frame total does not fit in CW bits");
  end
  if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  logic h_wrap, v_wrap, h_blank_next, v_blank_next;

  sync_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(HSYNC_POL), .W(CW)
  ) u_h (
    .clk(clk), .reset(reset), .advance(ce), .wrap(h_wrap), .pos(hpos),
    .sync(hsync), .blank(hblank), .blank_next(h_blank_next)
  );

  // Vertical axis steps only when the line wraps, so vsync/vblank move at hpos 0.
  sync_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(VSYNC_POL), .W(CW)
  ) u_v (
    .clk(clk), .reset(reset), .advance(h_wrap), .wrap(v_wrap), .pos(vpos),
    .sync(vsync), .blank(vblank), .blank_next(v_blank_next)
  );

  logic          display_on_q, display_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [FW-1:0] frame_count_q, frame_count_d;

  always_comb begin
    display_on_d  = ~h_blank_next & ~v_blank_next;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    frame_count_d = frame_count_q + FW'(v_wrap);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 15x8 mode: a frame-index model checked
// every cycle for both sync polarities, plus literal pins and pulse counts.
module tb_vga_timing_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CW = 4, FW = 4;

  logic clk = 1'b0;
  logic reset, ce;
  always #5 clk = ~clk;

  logic          hsync_a, vsync_a, don_a, hbl_a, vbl_a, ls_a, fs_a;
  logic [CW-1:0] hpos_a, vpos_a;
  logic [FW-1:0] fc_a;
  logic          hsync_b, vsync_b, don_b, hbl_b, vbl_b, ls_b, fs_b;
  logic [CW-1:0] hpos_b, vpos_b;
  logic [FW-1:0] fc_b;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(CW), .FW(FW)
  ) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .hsync(hsync_a), .vsync(vsync_a),
    .display_on(don_a), .hblank(hbl_a), .vblank(vbl_a), .hpos(hpos_a),
    .vpos(vpos_a), .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(CW), .FW(FW)
  ) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .hsync(hsync_b), .vsync(vsync_b),
    .display_on(don_b), .hblank(hbl_b), .vblank(vbl_b), .hpos(hpos_b),
    .vpos(vpos_b), .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: beam is a single index into the frame, h/v derived arithmetically.
  int pix = 0;
  bit m_ls = 1'b0, m_fs = 1'b0;
  int m_fc = 0;

  always @(posedge clk) begin
    if (reset !== 1'b1) begin
      pix = FRAME - 1; m_ls = 1'b0; m_fs = 1'b0; m_fc = 0;
    end else if (ce === 1'b1) begin
      pix  = (pix + 1) % FRAME;
      m_ls = (pix % HT) == 0;
      m_fs = (pix == 0);
      if (m_fs) m_fc = (m_fc + 1) % (1 << FW);
    end else begin
      m_ls = 1'b0; m_fs = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int h, v;
      bit hs_on, vs_on;
      h = pix % HT;
      v = pix / HT;
      hs_on = (h >= HD + HF) && (h <= HD + HF + HS - 1);
      vs_on = (v >= VD + VF) && (v <= VD + VF + VS - 1);
      chk("hpos_a", 32'(hpos_a), h);
      chk("vpos_a", 32'(vpos_a), v);
      chk("hsync_a", 32'(hsync_a), 32'(!hs_on));
      chk("vsync_a", 32'(vsync_a), 32'(!vs_on));
      chk("display_on_a", 32'(don_a), 32'((h < HD) && (v < VD)));
      chk("hblank_a", 32'(hbl_a), 32'(h >= HD));
      chk("vblank_a", 32'(vbl_a), 32'(v >= VD));
      chk("line_start_a", 32'(ls_a), 32'(m_ls));
      chk("frame_start_a", 32'(fs_a), 32'(m_fs));
      chk("frame_count_a", 32'(fc_a), m_fc);
      chk("hpos_b", 32'(hpos_b), h);
      chk("vpos_b", 32'(vpos_b), v);
      chk("hsync_b", 32'(hsync_b), 32'(hs_on));
      chk("vsync_b", 32'(vsync_b), 32'(vs_on));
      chk("display_on_b", 32'(don_b), 32'((h < HD) && (v < VD)));
      chk("line_start_b", 32'(ls_b), 32'(m_ls));
      chk("frame_start_b", 32'(fs_b), 32'(m_fs));
      chk("frame_count_b", 32'(fc_b), m_fc);
    end
  end

  task automatic cyc(input logic r, input logic c);
    reset = r;
    ce    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_hs, n_vs, n_don, n_ls, n_fs;
    bit found;

    reset = 1'b0;
    ce    = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk_en = 1'b1;
    chk("rst_hpos", 32'(hpos_a), 14);
    chk("rst_vpos", 32'(vpos_a), 7);
    chk("rst_hsync", 32'(hsync_a), 1);
    chk("rst_vsync", 32'(vsync_a), 1);
    chk("rst_display_on", 32'(don_a), 0);
    chk("rst_strobes", 32'({ls_a, fs_a}), 0);
    chk("rst_hsync_pol1", 32'(hsync_b), 0);

    cyc(1'b1, 1'b1);
    chk("first_hpos", 32'(hpos_a), 0);
    chk("first_vpos", 32'(vpos_a), 0);
    chk("first_display_on", 32'(don_a), 1);
    chk("first_strobes", 32'({ls_a, fs_a}), 3);
    chk("first_frame_count", 32'(fc_a), 1);

    // Two full frames of free run: per-frame sync/active counts are fixed.
    n_hs = 0; n_vs = 0; n_don = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc(1'b1, 1'b1);
      if (hsync_a == 1'b0) n_hs++;
      if (vsync_a == 1'b0) n_vs++;
      if (don_a) n_don++;
    end
    chk("freerun_hsync_cycles", n_hs, 48);
    chk("freerun_vsync_cycles", n_vs, 60);
    chk("freerun_active_cycles", n_don, 64);

    n_ls = 0;
    for (int i = 0; i < 240; i++) begin
      cyc(1'b1, (i % 4) == 0);
      if (ls_a) n_ls++;
    end
    chk("ce_div4_line_starts", n_ls, 4);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(63) != 0, $urandom_range(1) == 1);
    end

    cyc(1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc(1'b1, 1'b1);
      if (pix == 3 * HT + 5) begin found = 1'b1; break; end
    end
    chk("reach_5_3", 32'(found), 1);
    chk("mid_pos_hpos", 32'(hpos_a), 5);
    cyc(1'b0, 1'b1);
    chk("midrst_hpos", 32'(hpos_a), 14);
    chk("midrst_vpos", 32'(vpos_a), 7);
    chk("midrst_frame_count", 32'(fc_a), 0);
    chk("midrst_hblank_vblank", 32'({hbl_a, vbl_a}), 3);

    n_fs = 0;
    for (int i = 0; i < 17 * FRAME; i++) begin
      cyc(1'b1, 1'b1);
      if (fs_a) n_fs++;
      if (n_fs == 16 && fs_a) chk("wrap_to_zero", 32'(fc_a), 0);
    end
    chk("frame_pulses_17", n_fs, 17);
    chk("frame_count_after_17", 32'(fc_a), 1);

    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
